controller_sequencer: RTL and testbench



---
 rtl/sap1_pkg.sv | 52 +++++
 rtl/ring_counter.sv | 38 +++
 rtl/controller_sequencer.sv | 99 +++++++++
 tb/tb_controller_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 control definitions: opcodes, control-word bit positions,
// one-hot T-state codes and the fixed fetch words.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control word {Cp,Ep,Lm_n,CE_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
    localparam logic [3:0] CB_CP   = 4'd11;
    localparam logic [3:0] CB_EP   = 4'd10;
    localparam logic [3:0] CB_LM_N = 4'd9;
    localparam logic [3:0] CB_CE_N = 4'd8;
    localparam logic [3:0] CB_LI_N = 4'd7;
    localparam logic [3:0] CB_EI_N = 4'd6;
    localparam logic [3:0] CB_LA_N = 4'd5;
    localparam logic [3:0] CB_EA   = 4'd4;
    localparam logic [3:0] CB_SU   = 4'd3;
    localparam logic [3:0] CB_EU   = 4'd2;
    localparam logic [3:0] CB_LB_N = 4'd1;
    localparam logic [3:0] CB_LO_N = 4'd0;

    localparam int CTRL_W = 12;

    localparam logic [CTRL_W-1:0] CTRL_NOP = 12'h3E3;
    localparam logic [CTRL_W-1:0] CTRL_T1  = 12'h5E3;
    localparam logic [CTRL_W-1:0] CTRL_T2  = 12'hBE3;
    localparam logic [CTRL_W-1:0] CTRL_T3  = 12'h263;

    localparam logic [5:0] T1_OH = 6'b000001;
    localparam logic [5:0] T2_OH = 6'b000010;
    localparam logic [5:0] T3_OH = 6'b000100;
    localparam logic [5:0] T4_OH = 6'b001000;
    localparam logic [5:0] T5_OH = 6'b010000;
    localparam logic [5:0] T6_OH = 6'b100000;

    // Drive one control bit to its active level; NOP holds every bit inactive,
    // so the active level is simply the inverse of the NOP bit.
    function automatic logic [CTRL_W-1:0] ctrl_on(input logic [CTRL_W-1:0] w,
                                                  input logic [3:0] b);
        ctrl_on    = w;
        ctrl_on[b] = ~CTRL_NOP[b];
    endfunction

    function automatic logic op_defined(input logic [3:0] op);
        op_defined = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot T-state ring, advancing on the falling edge of clk.
// Illegal codes fall back to T1; hold freezes the ring, restart forces T1.
module ring_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] ring
);

    logic [5:0] ring_q;
    logic [5:0] ring_d;
    logic       onehot;

    always_comb begin
        onehot = (ring_q != 6'd0) && ((ring_q & (ring_q - 6'd1)) == 6'd0);
        ring_d = ring_q;
        if (!onehot || restart) begin
            ring_d = 6'b000001;
        end else if (!hold) begin
            ring_d = {ring_q[4:0], ring_q[5]};
        end
        if (onehot && hold) begin
            ring_d = ring_q;
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            ring_q <= 6'b000001;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring = ring_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: T-state ring plus combinational decode of the
// 12-bit control word from the ring state and IR opcode nibble.
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        opcode,
    output logic [CTRL_W-1:0] ctrl,
    output logic [5:0]        t_state,
    output logic              halt
);

    logic              halt_q;
    logic              halt_d;
    logic              ring_hold;
    logic              ring_restart;
    logic [5:0]        ring;
    logic [CTRL_W-1:0] ctrl_dec;
    logic [CTRL_W-1:0] w_mar_ir;

    ring_counter u_ring (
        .clk     (clk),
        .reset   (reset),
        .hold    (ring_hold),
        .restart (ring_restart),
        .ring    (ring)
    );

    // Halt is latched on the edge that ends T4 and the ring is held on that
    // same edge so it freezes at T4.
    always_comb begin
        halt_d = halt_q;
        if ((ring == T4_OH) && (opcode == OP_HLT)) begin
            halt_d = 1'b1;
        end
        ring_hold    = halt_d;
        ring_restart = 1'b0;
        if (SHORT_CYCLE) begin
            ring_restart = ((ring == T5_OH) && (opcode == OP_LDA)) ||
                           ((ring == T4_OH) && (opcode == OP_OUT)) ||
                           ((ring == T3_OH) && !op_defined(opcode));
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    always_comb begin
        w_mar_ir = ctrl_on(ctrl_on(CTRL_NOP, CB_EI_N), CB_LM_N);
        ctrl_dec = CTRL_NOP;
        case (ring)
            T1_OH: ctrl_dec = CTRL_T1;
            T2_OH: ctrl_dec = CTRL_T2;
            T3_OH: ctrl_dec = CTRL_T3;
            T4_OH: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: ctrl_dec = w_mar_ir;
                    OP_OUT: ctrl_dec = ctrl_on(ctrl_on(CTRL_NOP, CB_EA), CB_LO_N);
                    default: ctrl_dec = CTRL_NOP;
                endcase
            end
            T5_OH: begin
                case (opcode)
                    OP_LDA: ctrl_dec = ctrl_on(ctrl_on(CTRL_NOP, CB_CE_N), CB_LA_N);
                    OP_ADD: ctrl_dec = ctrl_on(ctrl_on(CTRL_NOP, CB_CE_N), CB_LB_N);
                    OP_SUB: ctrl_dec = ctrl_on(ctrl_on(ctrl_on(CTRL_NOP, CB_CE_N),
                                                       CB_LB_N), CB_SU);
                    default: ctrl_dec = CTRL_NOP;
                endcase
            end
            T6_OH: begin
                case (opcode)
                    OP_ADD: ctrl_dec = ctrl_on(ctrl_on(CTRL_NOP, CB_EU), CB_LA_N);
                    OP_SUB: ctrl_dec = ctrl_on(ctrl_on(ctrl_on(CTRL_NOP, CB_EU),
                                                       CB_LA_N), CB_SU);
                    default: ctrl_dec = CTRL_NOP;
                endcase
            end
            default: ctrl_dec = CTRL_NOP;
        endcase
        if (halt_q) begin
            ctrl_dec = CTRL_NOP;
        end
    end

    // Cp/Ep/Eu etc. must never pulse while reset is held, so NOP overrides decode.
    assign ctrl    = reset ? CTRL_NOP : ctrl_dec;
    assign t_state = ring;
    assign halt    = halt_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: one instance per SHORT_CYCLE setting,
// table vectors, directed halt/reset sequences and random instruction streams.
`timescale 1ns/1ps
module tb_controller_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  op0 = 4'h0;
    logic [3:0]  op1 = 4'h0;
    logic [11:0] ctrl0, ctrl1;
    logic [5:0]  ts0, ts1;
    logic        halt0, halt1;
    int          checks = 0;
    int          errors = 0;

    always #10 clk = ~clk;

    controller_sequencer #(.SHORT_CYCLE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .opcode(op0),
        .ctrl(ctrl0), .t_state(ts0), .halt(halt0));

    controller_sequencer #(.SHORT_CYCLE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(op1),
        .ctrl(ctrl1), .t_state(ts1), .halt(halt1));

    typedef struct {
        int          d;    // -1: apply a reset, else DUT index
        logic [3:0]  op;
        logic [5:0]  t;
        logic [11:0] c;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input int d, input logic [3:0] op,
                              input logic [5:0] t, input logic [11:0] c);
        vec_t e;
        e.d = d; e.op = op; e.t = t; e.c = c;
        tbl.push_back(e);
    endfunction

    // Reference: control word of step k (1..6) of an instruction, straight from the opcode table.
    function automatic logic [11:0] exp_word(input logic [3:0] op, input int k);
        if (k == 1) return 12'h5E3;
        if (k == 2) return 12'hBE3;
        if (k == 3) return 12'h263;
        case (op)
            4'h0: return (k == 4) ? 12'h1A3 : (k == 5) ? 12'h2C3 : 12'h3E3;
            4'h1: return (k == 4) ? 12'h1A3 : (k == 5) ? 12'h2E1 : 12'h3C7;
            4'h2: return (k == 4) ? 12'h1A3 : (k == 5) ? 12'h2E9 : 12'h3CF;
            4'hE: return (k == 4) ? 12'h3F2 : 12'h3E3;
            default: return 12'h3E3;
        endcase
    endfunction

    function automatic int instr_len(input logic [3:0] op, input bit sc);
        if (op == 4'hF) return 4;
        if (!sc) return 6;
        case (op)
            4'h0: return 5;
            4'h1, 4'h2: return 6;
            4'hE: return 4;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic sample(input int d, input logic [5:0] t, input logic [11:0] c,
                          input logic h, input string nm);
        if (d == 0) begin
            check({nm, ".ctrl0"}, ctrl0, c);
            check({nm, ".t_state0"}, 12'(ts0), 12'(t));
            check({nm, ".halt0"}, 12'(halt0), 12'(h));
        end else begin
            check({nm, ".ctrl1"}, ctrl1, c);
            check({nm, ".t_state1"}, 12'(ts1), 12'(t));
            check({nm, ".halt1"}, 12'(halt1), 12'(h));
        end
    endtask

    // Entered and left just after a falling edge; checks at the rising edge.
    task automatic cycle(input int d, input logic [3:0] op, input logic [5:0] t,
                         input logic [11:0] c, input logic h, input string nm);
        if (d == 0) op0 = op; else op1 = op;
        @(posedge clk); #1;
        sample(d, t, c, h, nm);
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        sample(0, 6'h01, 12'h3E3, 1'b0, "rst");
        sample(1, 6'h01, 12'h3E3, 1'b0, "rst");
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_instr(input int d, input logic [3:0] op, input bit junk, input string nm);
        int n;
        logic [3:0] o;
        n = instr_len(op, d == 1);
        for (int k = 1; k <= n; k++) begin
            o = (junk && k < 3) ? 4'($urandom_range(0, 15)) : op;
            cycle(d, o, 6'b000001 << (k - 1), exp_word(op, k), 1'b0, nm);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rop;
        // LDA x2, ADD and SUB with fetch-phase opcode toggling, then undefined 7
        for (int i = 0; i < 2; i++) begin
            v(0, 4'h0, 6'h01, 12'h5E3); v(0, 4'h0, 6'h02, 12'hBE3); v(0, 4'h0, 6'h04, 12'h263);
            v(0, 4'h0, 6'h08, 12'h1A3); v(0, 4'h0, 6'h10, 12'h2C3); v(0, 4'h0, 6'h20, 12'h3E3);
        end
        v(0, 4'hF, 6'h01, 12'h5E3); v(0, 4'h2, 6'h02, 12'hBE3); v(0, 4'h1, 6'h04, 12'h263);
        v(0, 4'h1, 6'h08, 12'h1A3); v(0, 4'h1, 6'h10, 12'h2E1); v(0, 4'h1, 6'h20, 12'h3C7);
        v(0, 4'hE, 6'h01, 12'h5E3); v(0, 4'h0, 6'h02, 12'hBE3); v(0, 4'h2, 6'h04, 12'h263);
        v(0, 4'h2, 6'h08, 12'h1A3); v(0, 4'h2, 6'h10, 12'h2E9); v(0, 4'h2, 6'h20, 12'h3CF);
        v(0, 4'h7, 6'h01, 12'h5E3); v(0, 4'h7, 6'h02, 12'hBE3); v(0, 4'h7, 6'h04, 12'h263);
        v(0, 4'h7, 6'h08, 12'h3E3); v(0, 4'h7, 6'h10, 12'h3E3); v(0, 4'h7, 6'h20, 12'h3E3);
        v(0, 4'h0, 6'h01, 12'h5E3);
        v(-1, 4'h0, 6'h00, 12'h000);
        // Short-cycle instance: OUT (4 steps), undefined 7 (3), LDA (5), ADD (6)
        v(1, 4'hE, 6'h01, 12'h5E3); v(1, 4'hE, 6'h02, 12'hBE3); v(1, 4'hE, 6'h04, 12'h263);
        v(1, 4'hE, 6'h08, 12'h3F2);
        v(1, 4'h7, 6'h01, 12'h5E3); v(1, 4'h7, 6'h02, 12'hBE3); v(1, 4'h7, 6'h04, 12'h263);
        v(1, 4'h0, 6'h01, 12'h5E3); v(1, 4'h0, 6'h02, 12'hBE3); v(1, 4'h0, 6'h04, 12'h263);
        v(1, 4'h0, 6'h08, 12'h1A3); v(1, 4'h0, 6'h10, 12'h2C3);
        v(1, 4'h1, 6'h01, 12'h5E3); v(1, 4'h1, 6'h02, 12'hBE3); v(1, 4'h1, 6'h04, 12'h263);
        v(1, 4'h1, 6'h08, 12'h1A3); v(1, 4'h1, 6'h10, 12'h2E1); v(1, 4'h1, 6'h20, 12'h3C7);
        v(1, 4'h0, 6'h01, 12'h5E3);

        #1 reset = 1'b1;
        #4;
        sample(0, 6'h01, 12'h3E3, 1'b0, "por");
        sample(1, 6'h01, 12'h3E3, 1'b0, "por");
        @(negedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            if (tbl[i].d < 0) do_reset();
            else cycle(tbl[i].d, tbl[i].op, tbl[i].t, tbl[i].c, 1'b0, $sformatf("tbl%0d", i));
        end

        // HLT: freeze at T4 for 20+ cycles regardless of opcode, then async reset exit
        do_reset();
        run_instr(0, 4'hF, 1'b0, "hlt");
        for (int i = 0; i < 22; i++) begin
            cycle(0, 4'($urandom_range(0, 15)), 6'h08, 12'h3E3, 1'b1, "halted");
        end
        #3 reset = 1'b1;
        #1 sample(0, 6'h01, 12'h3E3, 1'b0, "rst_halt");
        @(negedge clk); #1;
        reset = 1'b0;
        run_instr(0, 4'h0, 1'b0, "after_hlt");

        // Reset pulse between edges during T5 of ADD
        for (int k = 1; k <= 4; k++) cycle(0, 4'h1, 6'b000001 << (k - 1), exp_word(4'h1, k), 1'b0, "add_pre");
        op0 = 4'h1;
        @(posedge clk); #1;
        sample(0, 6'h10, 12'h2E1, 1'b0, "add_t5");
        #2 reset = 1'b1;
        #1 sample(0, 6'h01, 12'h3E3, 1'b0, "rst_mid");
        #1 reset = 1'b0;
        #1 sample(0, 6'h01, 12'h5E3, 1'b0, "post_rst");
        @(negedge clk); #1;
        for (int k = 2; k <= 6; k++) cycle(0, 4'h1, 6'b000001 << (k - 1), exp_word(4'h1, k), 1'b0, "add_re");

        // Random instruction streams on each instance
        for (int d = 0; d < 2; d++) begin
            do_reset();
            for (int i = 0; i < 30; i++) begin
                case ($urandom_range(0, 4))
                    0: rop = 4'h0;
                    1: rop = 4'h1;
                    2: rop = 4'h2;
                    3: rop = 4'hE;
                    default: rop = 4'($urandom_range(3, 13));
                endcase
                run_instr(d, rop, 1'b1, $sformatf("rnd%0d_%0d_op%h", d, i, rop));
            end
            cycle(d, 4'h0, 6'h01, 12'h5E3, 1'b0, "rnd_end");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
